fp_unpack: RTL and testbench
============================

# fp_unpack

Handshaked IEEE-754 operand unpacker for the floating-point datapath. It splits a packed word into a special-value code, sign, exponent and hidden-bit mantissa with zeroed protection bits, in the same field layout the rounding/packing stage consumes. Subnormal inputs are normalised by an iterative one-bit-per-cycle shift, so downstream arithmetic always sees a leading one. It sits at the operand inputs of the adder and multiplier front-ends.

## Interface
- `data_format`, default `` `FP32 ``, selects the format through the macros `` `GET_FP_LEN `` (F), `` `GET_EXP_LEN `` (E), `` `GET_MANTISSA_LEN `` (M) and `` `GET_PROTECT_LEN `` (P); W = M+P+1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous reset, active high.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  the block accepts `in_data` this cycle.
- `in_data`  in  F  packed word `{sign, exp[E-1:0], frac[M-1:0]}`.
- `out_valid`  out  1  the output fields are valid.
- `out_ready`  in  1  downstream accepts the output.
- `out_special`  out  2  `` `INF ``, `` `NAN ``, `` `ZERO `` or NORM, where NORM is the remaining 2-bit code.
- `out_sign`  out  1  sign.
- `out_exp`  out  E+1  biased exponent, two's complement; negative only for normalised subnormals.
- `out_mant`  out  W  `{hidden, frac, P zero bits}`.

## Operation
- States:
  - IDLE: empty.
  - NORM: subnormal shift in progress.
  - OUT: result held.
- Acceptance occurs when `in_valid & in_ready`.
- `in_ready` is 1 in IDLE, and in OUT when `out_ready`=1. It is 0 in NORM and while `rst`=1.
- Decode at acceptance (e = exp field, f = frac field):
  - e all ones, f=0: `` `INF ``, sign kept, `out_exp` = {0, all ones}, mant 0. Next state OUT.
  - e all ones, f≠0: `` `NAN ``, sign forced 0, `out_exp` = {0, all ones}, mant = {0, 1, zeros}. The NaN is canonicalised and the payload is dropped. Next state OUT.
  - e=0, f=0: `` `ZERO ``, sign kept, exp 0, mant 0. Next state OUT.
  - e≠0, not all ones: NORM code, `out_exp` = {0, e}, mant = {1, f, P'b0}. Next state OUT.
  - e=0, f≠0: NORM code, exp register loaded with 1, mant register loaded with {0, f, P'b0}. Next state NORM.
- In NORM, each cycle shifts mant left by 1 and decrements exp by 1.
  - The cycle whose shift places a 1 at `mant[W-1]` moves to OUT.
  - The shift count is k+1, where k is the number of leading zeros of f.
  - The final `out_exp` is −k in two's complement. The minimum is 1−M, which always fits in E+1 bits.
- In OUT, `out_valid`=1.
  - `out_ready`=1 with `in_valid`=0: go to IDLE.
  - `out_ready`=1 with `in_valid`=1: the new word is accepted in the same cycle and decoded as from IDLE (back-to-back).
  - `out_ready`=0: hold.
- The output fields are registers. They are stable whenever `out_valid`=1 and `out_ready`=0.
- In IDLE and NORM, `out_valid`=0 and the field values are don't-care. The bench must not check them there.

## Timing
- Reset: state IDLE, `out_valid`=0, `out_special`=`` `ZERO ``, `out_sign`=0, `out_exp`=0, `out_mant`=0.
- `rst` has priority over every other event. Asserting it mid-NORM or mid-OUT discards the operand.
- Latency from acceptance edge to `out_valid` rising:
  - Normal and special inputs: 1 edge.
  - Subnormal inputs: k+2 edges.
- Throughput is 1 word per cycle for non-subnormal streams while `out_ready`=1.
- Decode uses only `in_data` sampled at acceptance. `in_data` is ignored whenever `in_ready`=0.

## Test plan
- FP32 `0x3F800000` with `out_ready`=1 → one edge later `out_valid`=1, NORM code, sign 0, exp `0x07F`, mant = {1, 23'b0, P'b0}. `out_valid` drops the next cycle if `in_valid`=0.
- Specials, one word per cycle:
  - `0x7F800000` → `` `INF ``, sign 0, exp `0x0FF`, mant 0.
  - `0xFF800001` → `` `NAN ``, sign 0, mant = {0, 1, 22'b0, P'b0}.
  - `0x80000000` → `` `ZERO ``, sign 1.
  - `out_valid` stays high for 3 consecutive cycles.
- Subnormals:
  - `0x00400000` → 1 shift, `out_valid` 2 edges after acceptance, exp 0, mant = {1, 0...}.
  - `0x00000001` → 23 shifts, `out_valid` 24 edges after acceptance, exp `0x1EA` (−22), mant = {1, 0...}.
  - `in_ready`=0 throughout NORM in both cases.
- Backpressure: hold `out_ready`=0 for 5 cycles with `in_valid`=1 → outputs constant and no new acceptance. Raise `out_ready` → the old result is consumed and the new word is accepted on the same edge.
- Reset mid-NORM: feed `0x00000001`, then assert `rst` for 1 cycle after 10 shifts → `out_valid` stays 0 and the state is IDLE. A following `0x40000000` yields exp `0x080` after 1 edge.
- Random stream, 10k words, random `out_ready`: results compared against a reference model. No word is lost or duplicated, and order is preserved.

Source files
------------

// File: rtl/fp_unpack.sv
// IEEE-754 operand unpacker: splits a packed word into special code, sign, exponent and
// hidden-bit mantissa; subnormals are normalised one bit per cycle.

`ifndef FP_UNPACK_DEFS
`define FP_UNPACK_DEFS
`define FP16 0
`define FP32 1
`define FP64 2
`define GET_FP_LEN(fmt)       ((fmt) == `FP16 ? 16 : (fmt) == `FP64 ? 64 : 32)
`define GET_EXP_LEN(fmt)      ((fmt) == `FP16 ? 5  : (fmt) == `FP64 ? 11 : 8)
`define GET_MANTISSA_LEN(fmt) ((fmt) == `FP16 ? 10 : (fmt) == `FP64 ? 52 : 23)
`define GET_PROTECT_LEN(fmt)  3
`define ZERO 2'b00
`define INF  2'b01
`define NAN  2'b10
`endif

module fp_unpack #(
   parameter int data_format = `FP32,
   localparam int unsigned F = `GET_FP_LEN(data_format),
   localparam int unsigned E = `GET_EXP_LEN(data_format),
   localparam int unsigned M = `GET_MANTISSA_LEN(data_format),
   localparam int unsigned P = `GET_PROTECT_LEN(data_format),
   localparam int unsigned W = M + P + 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [F-1:0]   in_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [1:0]     out_special,
   output logic           out_sign,
   output logic [E:0]     out_exp,
   output logic [W-1:0]   out_mant
);

   localparam logic [1:0]   SP_NORM   = 2'b11;
   localparam logic [E:0]   EXP_MAX   = {1'b0, {E{1'b1}}};
   localparam logic [E:0]   EXP_ONE   = (E+1)'(1);
   localparam logic [W-1:0] MANT_QNAN = W'(1) << (W - 2);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_NORM = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic           r_valid,   w_valid_nxt;
   logic [1:0]     r_special, w_special_nxt;
   logic           r_sign,    w_sign_nxt;
   logic [E:0]     r_exp,     w_exp_nxt;
   logic [W-1:0]   r_mant,    w_mant_nxt;

   logic           w_in_sign;
   logic [E-1:0]   w_in_exp;
   logic [M-1:0]   w_in_frac;
   logic           w_exp_ones;
   logic           w_exp_zero;
   logic           w_frac_zero;
   logic           w_accept;

   state_t         w_dec_state;
   logic [1:0]     w_dec_special;
   logic           w_dec_sign;
   logic [E:0]     w_dec_exp;
   logic [W-1:0]   w_dec_mant;

   assign w_in_sign   = in_data[F-1];
   assign w_in_exp    = in_data[F-2 -: E];
   assign w_in_frac   = in_data[M-1:0];
   assign w_exp_ones  = &w_in_exp;
   assign w_exp_zero  = ~|w_in_exp;
   assign w_frac_zero = ~|w_in_frac;

   // Ready in IDLE, or in OUT when the held result is being consumed this cycle.
   assign in_ready = ~rst & ((r_state == S_IDLE) | ((r_state == S_OUT) & out_ready));
   assign w_accept = in_valid & in_ready;

   // Field decode of the incoming word; subnormals start at exp 1 with no hidden bit.
   always_comb begin
      w_dec_state   = S_OUT;
      w_dec_special = SP_NORM;
      w_dec_sign    = w_in_sign;
      w_dec_exp     = {1'b0, w_in_exp};
      w_dec_mant    = {1'b1, w_in_frac, {P{1'b0}}};
      if (w_exp_ones) begin
         w_dec_exp = EXP_MAX;
         if (w_frac_zero) begin
            w_dec_special = `INF;
            w_dec_mant    = '0;
         end else begin
            w_dec_special = `NAN;
            w_dec_sign    = 1'b0;
            w_dec_mant    = MANT_QNAN;
         end
      end else if (w_exp_zero) begin
         if (w_frac_zero) begin
            w_dec_special = `ZERO;
            w_dec_exp     = '0;
            w_dec_mant    = '0;
         end else begin
            w_dec_state = S_NORM;
            w_dec_exp   = EXP_ONE;
            w_dec_mant  = {1'b0, w_in_frac, {P{1'b0}}};
         end
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt   = r_state;
      w_valid_nxt   = r_valid;
      w_special_nxt = r_special;
      w_sign_nxt    = r_sign;
      w_exp_nxt     = r_exp;
      w_mant_nxt    = r_mant;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt   = w_dec_state;
               w_valid_nxt   = (w_dec_state == S_OUT);
               w_special_nxt = w_dec_special;
               w_sign_nxt    = w_dec_sign;
               w_exp_nxt     = w_dec_exp;
               w_mant_nxt    = w_dec_mant;
            end
         end
         S_NORM: begin
            w_mant_nxt = {r_mant[W-2:0], 1'b0};
            w_exp_nxt  = r_exp - EXP_ONE;
            if (r_mant[W-2]) begin
               w_state_nxt = S_OUT;
               w_valid_nxt = 1'b1;
            end
         end
         S_OUT: begin
            if (out_ready) begin
               if (w_accept) begin
                  w_state_nxt   = w_dec_state;
                  w_valid_nxt   = (w_dec_state == S_OUT);
                  w_special_nxt = w_dec_special;
                  w_sign_nxt    = w_dec_sign;
                  w_exp_nxt     = w_dec_exp;
                  w_mant_nxt    = w_dec_mant;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_valid_nxt = 1'b0;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_valid   <= 1'b0;
         r_special <= `ZERO;
         r_sign    <= 1'b0;
         r_exp     <= '0;
         r_mant    <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_valid   <= w_valid_nxt;
         r_special <= w_special_nxt;
         r_sign    <= w_sign_nxt;
         r_exp     <= w_exp_nxt;
         r_mant    <= w_mant_nxt;
      end
   end

   assign out_valid   = r_valid;
   assign out_special = r_special;
   assign out_sign    = r_sign;
   assign out_exp     = r_exp;
   assign out_mant    = r_mant;

endmodule

// File: tb/tb_fp_unpack.sv
// Self-checking bench for fp_unpack (FP32): directed scenarios plus a randomized stream
// scored against a field-level IEEE-754 reference model.

module tb_fp_unpack;

   localparam logic [1:0] C_ZERO = 2'b00;
   localparam logic [1:0] C_INF  = 2'b01;
   localparam logic [1:0] C_NAN  = 2'b10;
   localparam logic [1:0] C_NORM = 2'b11;
   localparam int         N_RAND = 10000;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_special;
   logic        out_sign;
   logic [8:0]  out_exp;
   logic [26:0] out_mant;

   int checks = 0;
   int errors = 0;

   fp_unpack dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_special (out_special),
      .out_sign    (out_sign),
      .out_exp     (out_exp),
      .out_mant    (out_mant)
   );

   always #5 clk = ~clk;

   // Reference: {special, sign, exp[8:0], mant[26:0]} from the IEEE-754 field rules.
   function automatic logic [38:0] model_fields(input logic [31:0] w);
      logic [7:0]  e;
      logic [22:0] f;
      logic        s;
      logic [1:0]  sp;
      logic [8:0]  x;
      logic [26:0] m;
      logic [23:0] sig;
      int          p;
      e = w[30:23];
      f = w[22:0];
      s = w[31];
      p = 0;
      if (e == 8'hFF) begin
         x = 9'h0FF;
         if (f == 23'd0) begin
            sp = C_INF;
            m  = 27'd0;
         end else begin
            sp = C_NAN;
            s  = 1'b0;
            m  = 27'd1 << 25;
         end
      end else if (e == 8'd0 && f == 23'd0) begin
         sp = C_ZERO;
         x  = 9'd0;
         m  = 27'd0;
      end else if (e != 8'd0) begin
         sp = C_NORM;
         x  = {1'b0, e};
         m  = {1'b1, f, 3'b000};
      end else begin
         for (int i = 0; i < 23; i++) if (f[i]) p = i;
         sp  = C_NORM;
         x   = 9'(p - 22);
         sig = 24'(f) << (23 - p);
         m   = {sig, 3'b000};
      end
      return {sp, s, x, m};
   endfunction

   // Edges from acceptance to out_valid: k+2 for subnormals (k leading zeros), else 1.
   function automatic int model_lat(input logic [31:0] w);
      int p;
      p = 0;
      if (w[30:23] != 8'd0 || w[22:0] == 23'd0) return 1;
      for (int i = 0; i < 23; i++) if (w[i]) p = i;
      return (22 - p) + 2;
   endfunction

   function automatic logic [31:0] gen_word();
      logic [31:0] r;
      logic [22:0] f;
      int          sel;
      r   = $urandom;
      sel = int'($urandom_range(0, 19));
      if (sel == 0) begin
         f = ($urandom_range(0, 1) == 0) ? 23'd0 : r[22:0];
         return {r[31], 8'hFF, f};
      end else if (sel == 1) begin
         return {r[31], 31'd0};
      end else if (sel == 2) begin
         f = r[22:0] >> $urandom_range(0, 22);
         if (f == 23'd0) f = 23'd1;
         return {r[31], 8'd0, f};
      end
      return {r[31], 8'($urandom_range(1, 254)), r[22:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_data = 32'h3F800000; out_ready = 1'b1;
      tick(); tick();
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", in_ready); end
      rst = 1'b0; in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
      checks++;
      if ({out_special, out_sign, out_exp, out_mant} !== {C_ZERO, 1'b0, 9'd0, 27'd0}) begin
         errors++;
         $display("FAIL reset_fields got %h want %h", {out_special, out_sign, out_exp, out_mant}, {C_ZERO, 37'd0});
      end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b want 1", in_ready); end
   endtask

   task automatic test_normal();
      in_valid = 1'b1; in_data = 32'h3F800000; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL normal_valid got %b want 1", out_valid); end
      checks++;
      if ({out_special, out_sign, out_exp, out_mant} !== {C_NORM, 1'b0, 9'h07F, 1'b1, 26'd0}) begin
         errors++;
         $display("FAIL normal_fields got %h want %h", {out_special, out_sign, out_exp, out_mant}, {C_NORM, 1'b0, 9'h07F, 1'b1, 26'd0});
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL normal_drop got %b want 0", out_valid); end
   endtask

   task automatic test_specials();
      logic [31:0] sw [3];
      sw[0] = 32'h7F800000; sw[1] = 32'hFF800001; sw[2] = 32'h80000000;
      in_valid = 1'b1; in_data = sw[0]; out_ready = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (out_valid !== 1'b1) begin errors++; $display("FAIL special%0d_valid got %b want 1", i, out_valid); end
         checks++;
         if ({out_special, out_sign, out_exp, out_mant} !== model_fields(sw[i])) begin
            errors++;
            $display("FAIL special%0d_fields got %h want %h", i, {out_special, out_sign, out_exp, out_mant}, model_fields(sw[i]));
         end
         if (i < 2) in_data = sw[i+1];
         else in_valid = 1'b0;
         tick();
      end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL special_drop got %b want 0", out_valid); end
   endtask

   task automatic test_subnormal(input logic [31:0] w);
      int n;
      in_valid = 1'b1; in_data = w; out_ready = 1'b0;
      tick();
      n = 1;
      while (out_valid !== 1'b1 && n < 40) begin
         in_data = $urandom;
         #1;
         checks++;
         if (in_ready !== 1'b0) begin errors++; $display("FAIL sub_%h_ready got %b want 0", w, in_ready); end
         tick();
         n++;
      end
      checks++;
      if (n != model_lat(w)) begin errors++; $display("FAIL sub_%h_latency got %0d want %0d", w, n, model_lat(w)); end
      checks++;
      if ({out_special, out_sign, out_exp, out_mant} !== model_fields(w)) begin
         errors++;
         $display("FAIL sub_%h_fields got %h want %h", w, {out_special, out_sign, out_exp, out_mant}, model_fields(w));
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL sub_%h_drop got %b want 0", w, out_valid); end
   endtask

   task automatic test_backpressure();
      logic [31:0] a, b;
      a = 32'h40490FDB; b = 32'hC0000000;
      in_valid = 1'b1; in_data = a; out_ready = 1'b0;
      tick();
      in_data = b;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL bp%0d_handshake got %b want 10", i, {out_valid, in_ready}); end
         checks++;
         if ({out_special, out_sign, out_exp, out_mant} !== model_fields(a)) begin
            errors++;
            $display("FAIL bp%0d_hold got %h want %h", i, {out_special, out_sign, out_exp, out_mant}, model_fields(a));
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || {out_special, out_sign, out_exp, out_mant} !== model_fields(b)) begin
         errors++;
         $display("FAIL bp_next got %b/%h want 1/%h", out_valid, {out_special, out_sign, out_exp, out_mant}, model_fields(b));
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drop got %b want 0", out_valid); end
   endtask

   task automatic test_reset_mid_norm();
      in_valid = 1'b1; in_data = 32'h00000001; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL rstnorm_idle got %b want 01", {out_valid, in_ready}); end
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL rstnorm_quiet%0d got %b want 0", i, out_valid); end
      end
      in_valid = 1'b1; in_data = 32'h40000000;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_exp !== 9'h080 || out_special !== C_NORM) begin
         errors++;
         $display("FAIL rstnorm_next got %b/%h/%h want 1/080/%h", out_valid, out_exp, out_special, C_NORM);
      end
      tick();
   endtask

   task automatic test_random_stream();
      logic [31:0] q[$];
      int          sent, cyc, wait_cnt;
      logic        exp_ready;
      sent = 0; cyc = 0; wait_cnt = 0;
      while ((sent < N_RAND || q.size() != 0) && cyc < 80000) begin
         in_valid  = (sent < N_RAND) && ($urandom_range(0, 9) < 8);
         in_data   = gen_word();
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         exp_ready = (q.size() == 0) || (out_valid && out_ready);
         checks++;
         if (in_ready !== exp_ready) begin errors++; $display("FAIL rand_ready cyc %0d got %b want %b", cyc, in_ready, exp_ready); end
         if (out_valid === 1'b1) begin
            checks++;
            wait_cnt = 0;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL rand_extra cyc %0d got %h want none", cyc, {out_special, out_sign, out_exp, out_mant});
            end else begin
               if ({out_special, out_sign, out_exp, out_mant} !== model_fields(q[0])) begin
                  errors++;
                  $display("FAIL rand_fields in %h got %h want %h", q[0], {out_special, out_sign, out_exp, out_mant}, model_fields(q[0]));
               end
               if (out_ready) void'(q.pop_front());
            end
         end else if (q.size() != 0) begin
            wait_cnt++;
            if (wait_cnt > 30) begin
               checks++; errors++;
               $display("FAIL rand_timeout in %h got no out_valid want within 30 cycles", q[0]);
               q.delete();
               wait_cnt = 0;
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(in_data);
            sent++;
         end
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      checks++;
      if (sent != N_RAND || q.size() != 0) begin
         errors++;
         $display("FAIL rand_count got sent %0d pending %0d want %0d/0", sent, q.size(), N_RAND);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      test_reset();
      test_normal();
      test_specials();
      test_subnormal(32'h00400000);
      test_subnormal(32'h00000001);
      test_backpressure();
      test_reset_mid_norm();
      test_random_stream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
